cache_refill_ctrl: RTL
======================

Name: cache_refill_ctrl

Overview:
- Miss-refill stage between the direct-mapped cache and main memory.
- Accepts one miss request from the cache and fetches the whole line from main memory, one word per request with a single request outstanding.
- Assembles the line and presents it to the cache as one fill transfer.
- Counts completed refills for the hit/miss statistics path.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width; the word is 4 bytes.
- WORDS_PER_LINE, 4, words per cache line; a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- miss_valid  in  1  cache presents a miss.
- miss_ready  out  1  block can accept a miss.
- miss_addr  in  ADDR_W  byte address that missed.
- mem_req_valid  out  1  word read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  word-aligned read address.
- mem_rsp_valid  in  1  read data returned.
- mem_rsp_data  in  DATA_W  read data.
- fill_valid  out  1  assembled line available.
- fill_ready  in  1  cache takes the line.
- fill_addr  out  ADDR_W  line-aligned base address.
- fill_data  out  DATA_W*WORDS_PER_LINE  line data; word i occupies bits [i*DATA_W +: DATA_W] and holds the word at fill_addr+4i.
- busy  out  1  high in every state except IDLE.
- refill_count  out  32  number of completed refills.
- crit_valid  out  1  one-cycle pulse carrying the missed word early (optional feature).
- crit_data  out  DATA_W  the missed word (optional feature).

Behaviour:
- Definitions: OFF_W = log2(WORDS_PER_LINE). Word offset = miss_addr[OFF_W+1:2]. Line base = miss_addr with bits [OFF_W+1:0] cleared.
- Reset: state IDLE. All outputs 0 except miss_ready=1. This includes refill_count=0, fill_data=0 and crit_valid=0.
- Reset mid-operation: any partial line is discarded, the FSM returns to IDLE, and refill_count is cleared.
- FSM has four states: IDLE, REQ, WAIT, FILL.
- IDLE:
  - miss_ready=1.
  - On miss_valid: latch line base and word offset, set the word index to its start value, clear the received-word mask, go to REQ.
- REQ:
  - mem_req_valid=1 and mem_req_addr = base + 4*idx.
  - mem_req_addr is held stable until mem_req_ready; the request is accepted on a cycle with both high.
  - After acceptance go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid: write mem_rsp_data into slot idx, then idx = (idx+1) mod WORDS_PER_LINE.
  - After WORDS_PER_LINE responses go to FILL; otherwise go to REQ.
- mem_rsp_valid in any state other than WAIT is ignored.
- FILL:
  - fill_valid=1; fill_addr and fill_data are held stable.
  - On fill_ready: refill_count += 1 (wraps at 2^32), then go to IDLE.
- miss_ready=0 outside IDLE. A miss_valid seen while busy is not accepted; the cache must hold it until the handshake.
- Only one memory request is outstanding at any time.
- Latency, with mem_req_ready tied high, the response one cycle after the request, and WORDS_PER_LINE=4:
  - miss accepted at cycle 0;
  - requests at cycles 1, 3, 5, 7;
  - fill_valid rises at cycle 9.
- A miss to the last word of memory space does not wrap: mem_req_addr is computed in ADDR_W bits and truncated.

Optional Feature:
- Macro: REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - The start index is the missed word offset; requests wrap, e.g. offset 2 → 2, 3, 0, 1.
  - On the first response, crit_valid pulses for one cycle with crit_data = that word, for an early restart.
- Undefined:
  - The start index is 0 and the order is 0..WORDS_PER_LINE-1.
  - crit_valid and crit_data are tied to 0.
- In both builds fill_data ordering is by address, not by arrival order.

Test Plan:
- Reset then idle → miss_ready=1, busy=0, refill_count=0, all valids 0.
- miss_addr=0x0000_1238, memory returns address-as-data, ready always high → requests 0x1230, 0x1234, 0x1238, 0x123C (undefined build); fill_addr=0x1230; fill_data words = 0x1230, 0x1234, 0x1238, 0x123C; fill_valid at cycle 9; refill_count=1.
- Same miss with REFILL_CRITICAL_WORD_FIRST_EN → request order 0x1238, 0x123C, 0x1230, 0x1234; crit_valid for one cycle with crit_data=0x1238; fill_data identical to the previous scenario.
- Backpressure: mem_req_ready low for 3 cycles on the second request and fill_ready low for 5 cycles → mem_req_addr stable and fill stable throughout; exactly 4 requests; refill_count increments once.
- Second miss_valid asserted while busy, plus spurious mem_rsp_valid in REQ and in IDLE → miss_ready=0 and the second miss is not accepted until return to IDLE; spurious data is not captured; fill_data is correct.
- reset asserted in WAIT after 2 words → next cycle IDLE, busy=0, refill_count=0; a new miss to 0x40 refills cleanly with no stale words.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_if
// Bundles every handshake and bus signal of the cache miss-refill stage.
//   miss_*      : miss request from the cache (valid/ready, byte address)
//   mem_req_*   : single-word read request to main memory (valid/ready/addr)
//   mem_rsp_*   : read data returned by main memory (valid/data, no ready)
//   fill_*      : assembled line handed to the cache (valid/ready/addr/data)
//   busy        : controller is not idle
//   refill_count: completed refills, for the statistics path
//   crit_*      : early copy of the missed word (critical-word-first builds)
// Modports:
//   master : the refill controller
//   slave  : the surrounding cache/memory environment
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic                             miss_valid;
  logic                             miss_ready;
  logic [ADDR_W-1:0]                miss_addr;
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [ADDR_W-1:0]                mem_req_addr;
  logic                             mem_rsp_valid;
  logic [DATA_W-1:0]                mem_rsp_data;
  logic                             fill_valid;
  logic                             fill_ready;
  logic [ADDR_W-1:0]                fill_addr;
  logic [DATA_W*WORDS_PER_LINE-1:0] fill_data;
  logic                             busy;
  logic [31:0]                      refill_count;
  logic                             crit_valid;
  logic [DATA_W-1:0]                crit_data;

  modport master (
    input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, fill_ready,
    output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data,
           busy, refill_count, crit_valid, crit_data
  );

  modport slave (
    output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, fill_ready,
    input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data,
           busy, refill_count, crit_valid, crit_data
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
// Miss-refill stage between a direct-mapped cache and main memory. Accepts one
// miss, fetches the whole line one word at a time with a single request
// outstanding, assembles it by address and hands it to the cache as one fill.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : cache_refill_ctrl_if.master (miss, mem_req, mem_rsp, fill,
//           busy, refill_count, crit_*)
// Optional build macro:
//   REFILL_CRITICAL_WORD_FIRST_EN - fetch starts at the missed word and wraps;
//   the first returned word is pulsed on crit_valid/crit_data. When undefined
//   the fetch order is 0..WORDS_PER_LINE-1 and crit_* are tied to zero.
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                clk,
  input  logic                reset,
  cache_refill_ctrl_if.master bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic [ADDR_W-1:0]         base_r;
  logic [OFF_W-1:0]          idx_r;
  logic [WORDS_PER_LINE-1:0] mask_r;
  logic [LINE_W-1:0]         line_r;
  logic [ADDR_W-1:0]         req_addr_r;
  logic                      miss_ready_r;
  logic                      req_valid_r;
  logic                      fill_valid_r;
  logic                      busy_r;
  logic [31:0]               count_r;

  logic                      miss_fire_s;
  logic                      rsp_fire_s;
  logic                      fill_fire_s;
  logic [ADDR_W-1:0]         line_base_s;
  logic [OFF_W-1:0]          start_idx_s;
  logic [OFF_W-1:0]          idx_inc_s;
  logic [WORDS_PER_LINE-1:0] mask_nxt_s;
  logic                      last_word_s;
  logic                      unused_addr_bits_s;

  // Base address plus word index; the low word-offset bits of base are zero,
  // so the sum never carries out of the line and truncates at ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [OFF_W-1:0]  idx);
    word_addr = base + ADDR_W'({idx, 2'b00});
  endfunction

  assign miss_fire_s = (state_r == ST_IDLE) && bus.miss_valid;
  assign rsp_fire_s  = (state_r == ST_WAIT) && bus.mem_rsp_valid;
  assign fill_fire_s = (state_r == ST_FILL) && bus.fill_ready;
  assign line_base_s = {bus.miss_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign idx_inc_s   = idx_r + OFF_W'(1);
  assign mask_nxt_s  = mask_r | (WORDS_PER_LINE'(1) << idx_r);
  assign last_word_s = &mask_nxt_s;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx_s        = bus.miss_addr[OFF_W+1:2];
  assign unused_addr_bits_s = ^bus.miss_addr[1:0];
`else
  assign start_idx_s        = {OFF_W{1'b0}};
  assign unused_addr_bits_s = ^bus.miss_addr[OFF_W+1:0];
`endif

  // Next-state decode of the refill FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.miss_valid) state_nxt_s = ST_REQ;
        else                state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_nxt_s = ST_WAIT;
        else                   state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) state_nxt_s = last_word_s ? ST_FILL : ST_REQ;
        else                   state_nxt_s = ST_WAIT;
      end
      ST_FILL: begin
        if (bus.fill_ready) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_FILL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered status/handshake outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      miss_ready_r <= 1'b1;
      req_valid_r  <= 1'b0;
      fill_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      miss_ready_r <= (state_nxt_s == ST_IDLE);
      req_valid_r  <= (state_nxt_s == ST_REQ);
      fill_valid_r <= (state_nxt_s == ST_FILL);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  // Line datapath: latched miss, word index, received mask, request address, line buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r     <= {ADDR_W{1'b0}};
      idx_r      <= {OFF_W{1'b0}};
      mask_r     <= {WORDS_PER_LINE{1'b0}};
      req_addr_r <= {ADDR_W{1'b0}};
      line_r     <= {LINE_W{1'b0}};
    end else if (miss_fire_s) begin
      base_r     <= line_base_s;
      idx_r      <= start_idx_s;
      mask_r     <= {WORDS_PER_LINE{1'b0}};
      req_addr_r <= word_addr(line_base_s, start_idx_s);
    end else if (rsp_fire_s) begin
      // Slot is chosen by address index, so arrival order never affects layout.
      line_r[idx_r*DATA_W +: DATA_W] <= bus.mem_rsp_data;
      idx_r      <= idx_inc_s;
      mask_r     <= mask_nxt_s;
      req_addr_r <= word_addr(base_r, idx_inc_s);
    end
  end

  // Completed-refill counter, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)            count_r <= 32'd0;
    else if (fill_fire_s) count_r <= count_r + 32'd1;
  end

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic              crit_valid_r;
  logic [DATA_W-1:0] crit_data_r;

  // One-cycle early copy of the first returned word, which is the missed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      crit_valid_r <= 1'b0;
      crit_data_r  <= {DATA_W{1'b0}};
    end else begin
      crit_valid_r <= rsp_fire_s && (mask_r == {WORDS_PER_LINE{1'b0}});
      if (rsp_fire_s && (mask_r == {WORDS_PER_LINE{1'b0}})) crit_data_r <= bus.mem_rsp_data;
    end
  end

  assign bus.crit_valid = crit_valid_r;
  assign bus.crit_data  = crit_data_r;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = {DATA_W{1'b0}};
`endif

  assign bus.miss_ready    = miss_ready_r;
  assign bus.mem_req_valid = req_valid_r;
  assign bus.mem_req_addr  = req_addr_r;
  assign bus.fill_valid    = fill_valid_r;
  assign bus.fill_addr     = base_r;
  assign bus.fill_data     = line_r;
  assign bus.busy          = busy_r;
  assign bus.refill_count  = count_r;
endmodule
